writeback_stage: RTL

- MEM/WB pipeline register plus write-back formatting for the MIPS core.
- Captures the instruction leaving the MEM stage. Aligns and sign/zero-extends load data, selects ALU, load or link result, and drives the register file write port (regWrite, write_reg, write_data_reg) one cycle later.
- Also reports misaligned loads and keeps a retired-instruction counter.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/load_align.sv | 61 ++++++
 rtl/writeback_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core encodings: write-back source select, load types and
// special register numbers.
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] LINK_REG = 5'd31;

endpackage

// File: rtl/load_align.sv
// Load data formatter: picks the byte/halfword addressed by the low address
// bits out of the raw memory word, extends it, and flags misaligned accesses.
module load_align
    import mips_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [2:0]        load_type,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

    function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] b);
        return {{(DATA_W-8){b[7]}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] h);
        return {{(DATA_W-16){h[15]}}, h};
    endfunction

    logic [1:0]  lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // lane counts byte positions from the LSB of the word
        lane = BIG_ENDIAN ? ~off : off;
        case (lane)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = (off[1] ^ BIG_ENDIAN) ? raw[31:16] : raw[15:0];

        data       = raw;
        misaligned = (off != 2'd0);
        case (load_type)
            LD_LH: begin
                data       = sext16(half_sel);
                misaligned = off[0];
            end
            LD_LHU: begin
                data       = {16'd0, half_sel};
                misaligned = off[0];
            end
            LD_LB: begin
                data       = sext8(byte_sel);
                misaligned = 1'b0;
            end
            LD_LBU: begin
                data       = {24'd0, byte_sel};
                misaligned = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with write-back result selection, misaligned-load
// reporting and a retired-instruction counter.
module writeback_stage
    import mips_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [4:0]        mem_dest,
    input  logic [1:0]        mem_wb_sel,
    input  logic [2:0]        mem_load_type,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic [DATA_W-1:0] mem_pc_plus4,
    input  logic              flush,
    output logic              regWrite,
    output logic [4:0]        write_reg,
    output logic [DATA_W-1:0] write_data_reg,
    output logic              wb_valid,
    output logic              misalign_err,
    output logic [DATA_W-1:0] bad_vaddr,
    output logic [CNT_W-1:0]  retire_count
);

    logic              take_p0;
    logic              load_mis_p0;
    logic              misaligned_p0;
    logic [DATA_W-1:0] load_fmt_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic              vld_p1;
    logic              rw_p1;
    logic              merr_p1;
    logic [4:0]        wreg_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [DATA_W-1:0] bad_p1;
    logic [CNT_W-1:0]  cnt_p1;

    load_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_load_align (
        .load_type  (mem_load_type),
        .off        (mem_alu_result[1:0]),
        .raw        (mem_load_data),
        .data       (load_fmt_p0),
        .misaligned (load_mis_p0)
    );

    // Stage p0: MEM-side result selection
    always_comb begin
        take_p0       = mem_valid & ~flush;
        misaligned_p0 = (mem_wb_sel == WB_SEL_LOAD) & load_mis_p0;
        case (mem_wb_sel)
            WB_SEL_LOAD: wdata_p0 = load_fmt_p0;
            WB_SEL_LINK: wdata_p0 = mem_pc_plus4 + 32'd4;
            default:     wdata_p0 = mem_alu_result;
        endcase
    end

    // Stage p1: WB register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            rw_p1    <= 1'b0;
            merr_p1  <= 1'b0;
            wreg_p1  <= 5'd0;
            wdata_p1 <= '0;
            bad_p1   <= '0;
            cnt_p1   <= '0;
        end else begin
            vld_p1  <= take_p0;
            rw_p1   <= take_p0 & mem_reg_write & (mem_dest != REG_ZERO) & ~misaligned_p0;
            merr_p1 <= take_p0 & misaligned_p0;
            if (take_p0) begin
                wreg_p1  <= mem_dest;
                wdata_p1 <= wdata_p0;
            end
            if (take_p0 & misaligned_p0)
                bad_p1 <= mem_alu_result;
            if (take_p0 & ~misaligned_p0)
                cnt_p1 <= cnt_p1 + CNT_W'(1);
        end
    end

    assign wb_valid       = vld_p1;
    assign regWrite       = rw_p1;
    assign misalign_err   = merr_p1;
    assign write_reg      = wreg_p1;
    assign write_data_reg = wdata_p1;
    assign bad_vaddr      = bad_p1;
    assign retire_count   = cnt_p1;

endmodule
